// File: rtl/kalman_pkg.sv
// kalman_pkg: shared widths, gain clamp value and FSM states for the Kalman-gain stage
package kalman_pkg;
  localparam int P_W = 23;
  localparam int K_W = 13;
  localparam int FRAC = 13;
  localparam logic [K_W-1:0] K_MAX = 13'h1FFF;
  typedef enum logic [2:0] {IDLE, SETUP, DIV0, DIV1, DONE} kg_state_t;
endpackage

// File: rtl/kalman_frac_div.sv
// kalman_frac_div: serial restoring divider producing one fraction bit of num/den per step
module kalman_frac_div
  import kalman_pkg::*;
#(
  parameter int P_W = kalman_pkg::P_W,
  parameter int K_W = kalman_pkg::K_W
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           load,
  input  logic           step,
  input  logic [P_W-1:0] num,
  input  logic [P_W:0]   den,
  output logic [K_W-1:0] q_nxt
);
  logic [P_W+1:0] rem, rs, rd;
  logic [K_W-1:0] q;
  logic ge;
  assign rs = {rem[P_W:0], 1'b0};
  assign ge = rs >= {1'b0, den};
  assign rd = ge ? rs - {1'b0, den} : rs;
  // q_nxt exposes the quotient including this cycle's bit, so the last bit can be consumed on the reload edge
  assign q_nxt = {q[K_W-2:0], ge};
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      rem <= '0;
      q <= '0;
    end else if (load) begin
      rem <= {2'b00, num};
      q <= '0;
    end else if (step) begin
      rem <= rd;
      q <= q_nxt;
    end
  end
endmodule

// File: rtl/kalman_gain_div.sv
// kalman_gain_div: K0 = P00/(P00+R), K1 = P10/(P00+R) as Q0.13 gains from one shared serial divider
module kalman_gain_div #(
  parameter int P_W = kalman_pkg::P_W,
  parameter int K_W = kalman_pkg::K_W
) (
  input  logic           clk,
  input  logic           n_rst,
  input  logic           start,
  input  logic [P_W-1:0] P00_in,
  input  logic [P_W-1:0] P10_in,
  input  logic [P_W-1:0] R_in,
  output logic           busy,
  output logic           done,
  output logic [K_W-1:0] K0_out,
  output logic [K_W-1:0] K1_out,
  output logic           sat,
  output logic           div_zero
);
  import kalman_pkg::*;
  kg_state_t st, st_nxt;
  logic [3:0] cnt;
  logic [P_W-1:0] p00, p10, rr, num;
  logic [P_W:0] s, s_sum;
  logic [K_W-1:0] q0, qn;
  logic z, s0, s1, last, load, step;
  assign s_sum = {1'b0, p00} + {1'b0, rr};
  assign last = cnt == 4'd12;
  always_comb begin
    st_nxt = (st == IDLE && start) ? SETUP :
             (st == SETUP) ? DIV0 :
             (st == DIV0 && last) ? DIV1 :
             (st == DIV1 && last) ? DONE :
             (st == DONE) ? IDLE : st;
    busy = st == SETUP || st == DIV0 || st == DIV1;
    done = st == DONE;
    step = st == DIV0 || st == DIV1;
    load = st == SETUP || (st == DIV0 && last);
    num = st == SETUP ? p00 : p10;
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) st <= IDLE;
    else st <= st_nxt;
  end
  kalman_frac_div #(.P_W(P_W), .K_W(K_W)) u_div (
    .clk(clk),
    .n_rst(n_rst),
    .load(load),
    .step(step),
    .num(num),
    .den(s),
    .q_nxt(qn)
  );
  // iterations always run to completion; flags only override the final register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      cnt <= '0;
      p00 <= '0;
      p10 <= '0;
      rr <= '0;
      s <= '0;
      z <= 1'b0;
      s0 <= 1'b0;
      s1 <= 1'b0;
      q0 <= '0;
      K0_out <= '0;
      K1_out <= '0;
      sat <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      cnt <= step ? (last ? 4'd0 : cnt + 4'd1) : cnt;
      if (st == IDLE && start) begin
        p00 <= P00_in;
        p10 <= P10_in;
        rr <= R_in;
      end
      if (st == SETUP) begin
        s <= s_sum;
        z <= s_sum == '0;
        s0 <= {1'b0, p00} >= s_sum;
        s1 <= {1'b0, p10} >= s_sum;
      end
      if (st == DIV0 && last) q0 <= qn;
      if (st == DIV1 && last) begin
        K0_out <= z ? '0 : s0 ? {K_W{1'b1}} : q0;
        K1_out <= z ? '0 : s1 ? {K_W{1'b1}} : qn;
        sat <= !z && (s0 || s1);
        div_zero <= z;
      end
    end
  end
endmodule

// File: tb/tb_kalman_gain_div.sv
// tb_kalman_gain_div: vector table plus scoreboard checks of gains, flags, latency and abort behaviour
module tb_kalman_gain_div;
  localparam int PER = 10;
  logic clk = 0, n_rst = 1, start = 0;
  logic [22:0] p00_in = 0, p10_in = 0, r_in = 0;
  logic busy, done, sat, div_zero;
  logic [12:0] k0_out, k1_out;
  typedef struct {
    logic [22:0] p00, p10, r;
    logic [12:0] k0, k1;
    logic sat, dz;
  } vec_t;
  typedef struct {
    vec_t v;
    time t0;
  } sb_t;
  sb_t sbq[$];
  int tests = 0, fails = 0;
  always #(PER/2) clk = ~clk;
  kalman_gain_div dut (
    .clk(clk), .n_rst(n_rst), .start(start),
    .P00_in(p00_in), .P10_in(p10_in), .R_in(r_in),
    .busy(busy), .done(done), .K0_out(k0_out), .K1_out(k1_out),
    .sat(sat), .div_zero(div_zero)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask
  function automatic vec_t model(input logic [22:0] a, input logic [22:0] b, input logic [22:0] r);
    vec_t v;
    longint s;
    s = longint'(a) + longint'(r);
    v.p00 = a;
    v.p10 = b;
    v.r = r;
    v.dz = s == 0;
    v.k0 = (s == 0) ? 13'd0 : (longint'(a) >= s) ? 13'd8191 : 13'((longint'(a) << 13) / s);
    v.k1 = (s == 0) ? 13'd0 : (longint'(b) >= s) ? 13'd8191 : 13'((longint'(b) << 13) / s);
    v.sat = (s != 0) && (longint'(a) >= s || longint'(b) >= s);
    return v;
  endfunction
  always @(negedge clk) begin
    sb_t e;
    if (done) begin
      if (sbq.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("k0", k0_out, e.v.k0);
        chk("k1", k1_out, e.v.k1);
        chk("sat", sat, e.v.sat);
        chk("div_zero", div_zero, e.v.dz);
        chk("latency", longint'($time - e.t0), 27*PER + PER/2);
        chk("busy_in_done", busy, 0);
      end
    end
  end
  task automatic drive(input vec_t v);
    p00_in = v.p00;
    p10_in = v.p10;
    r_in = v.r;
  endtask
  task automatic go(input vec_t v, input bit push);
    @(negedge clk);
    drive(v);
    start = 1;
    @(posedge clk);
    if (push) sbq.push_back('{v, $time});
    #1 start = 0;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic wait_idle();
    int n = 0;
    while (sbq.size() != 0 && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("timeout_pending", sbq.size(), 0);
      sbq.delete();
    end
  endtask
  initial begin
    vec_t tbl[8];
    vec_t v;
    time t0;
    tbl[0] = '{23'd1000, 23'd500, 23'd1000, 13'd4096, 13'd2048, 1'b0, 1'b0};
    tbl[1] = '{23'd1, 23'd2, 23'd2, 13'd2730, 13'd5461, 1'b0, 1'b0};
    tbl[2] = '{23'd5, 23'd9, 23'd0, 13'd8191, 13'd8191, 1'b1, 1'b0};
    tbl[3] = '{23'd0, 23'd7, 23'd0, 13'd0, 13'd0, 1'b0, 1'b1};
    tbl[4] = '{23'd8388607, 23'd8388607, 23'd1, 13'd8191, 13'd8191, 1'b0, 1'b0};
    tbl[5] = '{23'd0, 23'd100, 23'd50, 13'd0, 13'd8191, 1'b1, 1'b0};
    tbl[6] = '{23'd3, 23'd1, 23'd5, 13'd3072, 13'd1024, 1'b0, 1'b0};
    tbl[7] = '{23'd2, 23'd7, 23'd6, 13'd2048, 13'd7168, 1'b0, 1'b0};
    #2 n_rst = 0;
    #(3*PER);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_k0", k0_out, 0);
    chk("rst_k1", k1_out, 0);
    chk("rst_sat", sat, 0);
    chk("rst_dz", div_zero, 0);
    @(negedge clk) n_rst = 1;
    foreach (tbl[i]) begin
      go(tbl[i], 1);
      wait_idle();
    end
    for (int k = 0; k < 8; k++) begin
      v = model(23'($urandom_range(0, 8388607)), 23'($urandom_range(0, 8388607)),
                (k % 3 == 0) ? 23'd0 : 23'($urandom_range(0, 8388607)));
      go(v, 1);
      wait_idle();
    end
    @(negedge clk);
    drive(tbl[0]);
    start = 1;
    @(posedge clk);
    t0 = $time;
    sbq.push_back('{tbl[0], t0});
    sbq.push_back('{tbl[1], t0 + 29*PER});
    repeat (5) @(negedge clk);
    drive(tbl[1]);
    repeat (30) @(negedge clk);
    drive(tbl[2]);
    repeat (10) @(negedge clk);
    start = 0;
    wait_idle();
    repeat (35) @(posedge clk);
    go(tbl[0], 0);
    repeat (10) @(negedge clk);
    n_rst = 0;
    #1;
    chk("abort_k0", k0_out, 0);
    chk("abort_k1", k1_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_sat", sat, 0);
    @(negedge clk) n_rst = 1;
    repeat (40) @(posedge clk);
    go('{23'd1000, 23'd500, 23'd3000, 13'd2048, 13'd1024, 1'b0, 1'b0}, 1);
    wait_idle();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
